// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: valid/ready handshake, flush, writeback-source mux and EX forwarding tap.
// Define MEM_WB_SKID_EN to add a 2-entry skid buffer with in_ready driven from a flop.
module mem_wb_stage #(
    parameter int XLEN  = 32,
    parameter int RD_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RD_W-1:0]  in_rd,
    input  logic             in_reg_write,
    input  logic [1:0]       in_wb_sel,
    input  logic [XLEN-1:0]  in_mem_data,
    input  logic [XLEN-1:0]  in_alu_out,
    input  logic [XLEN-1:0]  in_pc_inc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_reg_write,
    output logic [XLEN-1:0]  out_wb_data,
    output logic             fwd_en,
    output logic [RD_W-1:0]  fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic            reg_write;
        logic [1:0]      wb_sel;
        logic [XLEN-1:0] mem_data;
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] pc_inc;
    } entry_t;

    entry_t in_entry;
    entry_t main_q;
    logic   main_valid;
    logic   take_in;
    logic   take_out;

    assign in_entry = '{rd: in_rd, reg_write: in_reg_write, wb_sel: in_wb_sel,
                        mem_data: in_mem_data, alu_out: in_alu_out, pc_inc: in_pc_inc};
    assign take_in  = in_valid && in_ready;
    assign take_out = main_valid && out_ready;

`ifdef MEM_WB_SKID_EN
    entry_t skid_q;
    logic   skid_valid;
    logic   in_ready_q;
    logic   load_main_from_skid;
    logic   load_main_from_in;
    logic   load_skid;

    // take_in implies the skid is empty, so a new beat can never overtake a skid entry
    always_comb begin
        load_main_from_skid = skid_valid && take_out;
        load_main_from_in   = take_in && (!main_valid || take_out);
        load_skid           = take_in && main_valid && !take_out;
    end

    assign in_ready = in_ready_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            if (load_main_from_skid || load_main_from_in)
                main_valid <= 1'b1;
            else if (take_out)
                main_valid <= 1'b0;
            if (load_skid)
                skid_valid <= 1'b1;
            else if (load_main_from_skid)
                skid_valid <= 1'b0;
            in_ready_q <= !(load_skid || (skid_valid && !load_main_from_skid));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (!flush) begin
            if (load_main_from_skid)
                main_q <= skid_q;
            else if (load_main_from_in)
                main_q <= in_entry;
            if (load_skid)
                skid_q <= in_entry;
        end
    end
`else
    assign in_ready = !main_valid || out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            main_valid <= 1'b0;
        else if (flush)
            main_valid <= 1'b0;
        else if (take_in)
            main_valid <= 1'b1;
        else if (take_out)
            main_valid <= 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            main_q <= '0;
        else if (!flush && take_in)
            main_q <= in_entry;
    end
`endif

    always_comb begin
        out_wb_data = '0;
        case (main_q.wb_sel)
            2'b00:   out_wb_data = main_q.alu_out;
            2'b01:   out_wb_data = main_q.mem_data;
            2'b10:   out_wb_data = main_q.pc_inc;
            default: out_wb_data = '0;
        endcase
    end

    // x0 is never forwarded even though the write itself still reaches WB
    assign out_valid     = main_valid;
    assign out_rd        = main_q.rd;
    assign out_reg_write = main_q.reg_write && main_valid;
    assign fwd_en        = out_reg_write && (out_rd != '0);
    assign fwd_rd        = out_rd;
    assign fwd_data      = out_wb_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (main_valid && !out_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: the reference model is a bounded FIFO of expected writebacks.
// Works with or without MEM_WB_SKID_EN.
module tb_mem_wb_stage;

    localparam int XLEN      = 32;
    localparam int RD_W      = 5;
    localparam int CNT_W     = 4;
    localparam int STALL_MAX = (1 << CNT_W) - 1;
`ifdef MEM_WB_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [RD_W-1:0]  in_rd;
    logic             in_reg_write;
    logic [1:0]       in_wb_sel;
    logic [XLEN-1:0]  in_mem_data;
    logic [XLEN-1:0]  in_alu_out;
    logic [XLEN-1:0]  in_pc_inc;
    logic             out_valid;
    logic             out_ready;
    logic [RD_W-1:0]  out_rd;
    logic             out_reg_write;
    logic [XLEN-1:0]  out_wb_data;
    logic             fwd_en;
    logic [RD_W-1:0]  fwd_rd;
    logic [XLEN-1:0]  fwd_data;
    logic [CNT_W-1:0] stall_cnt;

    typedef struct {
        logic [RD_W-1:0] rd;
        logic            rw;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   total = 0;
    int   bad = 0;
    int   expStall = 0;
    bit   modelReady;
    bit   acc;

    mem_wb_stage #(.XLEN(XLEN), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
        .in_mem_data(in_mem_data), .in_alu_out(in_alu_out), .in_pc_inc(in_pc_inc),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_wb_data(out_wb_data),
        .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] wbValue(input logic [1:0] sel, input logic [XLEN-1:0] alu,
                                                input logic [XLEN-1:0] mem, input logic [XLEN-1:0] pc);
        case (sel)
            2'b00:   return alu;
            2'b01:   return mem;
            2'b10:   return pc;
            default: return '0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle: drive at posedge+1, check state at posedge+2, book-keep the model at negedge
    task automatic applyStimulus(input logic v, input logic [RD_W-1:0] rd, input logic rw,
                                 input logic [1:0] sel, input logic [XLEN-1:0] mem,
                                 input logic [XLEN-1:0] alu, input logic [XLEN-1:0] pc,
                                 input logic ordy, input logic fl, output bit accepted);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v; in_rd = rd; in_reg_write = rw; in_wb_sel = sel;
        in_mem_data = mem; in_alu_out = alu; in_pc_inc = pc;
        out_ready = ordy; flush = fl;
        #1;
        modelReady = SKID ? (expQ.size() < 2) : (expQ.size() == 0 || ordy);
        checkOutput("in_ready", 64'(in_ready), 64'(modelReady));
        checkOutput("out_valid", 64'(out_valid), 64'(expQ.size() > 0));
        checkOutput("stall_cnt", 64'(stall_cnt), 64'(expStall));
        if (expQ.size() == 0) begin
            checkOutput("idle_reg_write", 64'(out_reg_write), 64'd0);
            checkOutput("idle_fwd_en", 64'(fwd_en), 64'd0);
        end
        if (expQ.size() > 0 && !ordy && expStall < STALL_MAX)
            expStall++;
        accepted = v && modelReady && !fl;
        @(negedge clk);
        if (fl) begin
            expQ.delete();
        end else if (accepted) begin
            e.rd = rd; e.rw = rw; e.data = wbValue(sel, alu, mem, pc);
            expQ.push_back(e);
        end
    endtask

    task automatic idleCycle(input logic ordy);
        bit a;
        applyStimulus(1'b0, '0, 1'b0, 2'b00, '0, '0, '0, ordy, 1'b0, a);
    endtask

    task automatic drainAll();
        for (int i = 0; i < 10 && expQ.size() > 0; i++)
            idleCycle(1'b1);
        if (expQ.size() > 0) begin
            total++; bad++;
            $display("[TB] FAIL drain_timeout actual=%0d entries left required=0", expQ.size());
        end
    endtask

    // Reset lands between edges with a beat on the inputs; outputs must clear without a clock
    task automatic applyReset();
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_rd = 5'($urandom); in_reg_write = 1'($urandom);
        in_wb_sel = 2'($urandom); in_mem_data = $urandom; in_alu_out = $urandom;
        in_pc_inc = $urandom; out_ready = 1'($urandom); flush = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_reg_write", 64'(out_reg_write), 64'd0);
        checkOutput("rst_fwd_en", 64'(fwd_en), 64'd0);
        checkOutput("rst_out_rd", 64'(out_rd), 64'd0);
        checkOutput("rst_out_wb_data", 64'(out_wb_data), 64'd0);
        checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        expQ.delete();
        expStall = 0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                total++; bad++;
                $display("[TB] FAIL unexpected_beat actual rd=%0h data=%0h required=none", out_rd, out_wb_data);
            end else begin
                monE = expQ.pop_front();
                checkOutput("out_rd", 64'(out_rd), 64'(monE.rd));
                checkOutput("out_reg_write", 64'(out_reg_write), 64'(monE.rw));
                checkOutput("out_wb_data", 64'(out_wb_data), 64'(monE.data));
                checkOutput("fwd_en", 64'(fwd_en), 64'(monE.rw && monE.rd != 0));
                checkOutput("fwd_rd", 64'(fwd_rd), 64'(monE.rd));
                checkOutput("fwd_data", 64'(fwd_data), 64'(monE.data));
            end
        end
    end

    initial begin
        logic [RD_W-1:0] bRd[3];
        logic [XLEN-1:0] bAlu[3];
        int idx;
        bit fl;
        bit ordy;

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_rd = '0; in_reg_write = 1'b0; in_wb_sel = 2'b00;
        in_mem_data = '0; in_alu_out = '0; in_pc_inc = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        $display("[TB] writeback mux and forward tap");
        for (int s = 0; s < 4; s++)
            applyStimulus(1'b1, 5'd5, 1'b1, 2'(s), 32'h22, 32'h11, 32'h33, 1'b1, 1'b0, acc);
        $display("[TB] x0 suppression");
        applyStimulus(1'b1, 5'd0, 1'b1, 2'b00, 32'h1, 32'h2, 32'h3, 1'b1, 1'b0, acc);
        drainAll();

        $display("[TB] back-pressure");
        applyReset();
        bRd  = '{5'd10, 5'd11, 5'd12};
        bAlu = '{32'hA, 32'hB, 32'hC};
        idx = 0;
        for (int cyc = 0; cyc < 40 && (idx < 3 || expQ.size() > 0); cyc++) begin
            ordy = !(cyc >= 1 && cyc <= 4);
            if (idx < 3) begin
                applyStimulus(1'b1, bRd[idx], 1'b1, 2'b00, '0, bAlu[idx], '0, ordy, 1'b0, acc);
                if (acc) idx++;
            end else begin
                idleCycle(ordy);
            end
        end
        if (idx < 3 || expQ.size() > 0) begin
            total++; bad++;
            $display("[TB] FAIL bp_timeout actual sent=%0d left=%0d required sent=3 left=0", idx, expQ.size());
        end
        checkOutput("bp_stall_cnt", 64'(stall_cnt), 64'd4);

        $display("[TB] flush");
        applyReset();
        applyStimulus(1'b1, 5'd1, 1'b1, 2'b00, '0, 32'h100, '0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 5'd2, 1'b1, 2'b00, '0, 32'h200, '0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 5'd3, 1'b1, 2'b00, '0, 32'h300, '0, 1'b0, 1'b1, acc);
        idleCycle(1'b1);
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        repeat (2) idleCycle(1'b1);

        $display("[TB] stall counter saturation");
        applyReset();
        applyStimulus(1'b1, 5'd7, 1'b1, 2'b01, 32'h77, '0, '0, 1'b0, 1'b0, acc);
        repeat (20) idleCycle(1'b0);
        checkOutput("sat_stall_cnt", 64'(stall_cnt), 64'd15);
        drainAll();

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            if (i == 200) applyReset();
            fl   = ($urandom_range(0, 19) == 0);
            ordy = fl ? 1'b0 : ($urandom_range(0, 3) != 0);
            applyStimulus(1'($urandom), 5'($urandom), 1'($urandom), 2'($urandom),
                          $urandom, $urandom, $urandom, ordy, fl, acc);
        end
        drainAll();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
